// File: rtl/cla_multicycle_adder_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder:
// FSM state encoding and the slice width.
package cla_multicycle_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    // Width of the nibble index register; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/cla_multicycle_adder_cla4_slice.sv
// Four-bit combinational carry-lookahead slice: all internal carries are
// formed directly from generate/propagate terms rather than rippling.
import cla_multicycle_adder_pkg::*;

module cla4_slice (
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    always_comb begin
        g = a & b;
        p = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[NIBBLE_W-1:0];
        cout = c[NIBBLE_W];
    end

endmodule

// File: rtl/cla_multicycle_adder.sv
// Wide adder that streams latched operands through one 4-bit CLA slice a
// nibble per cycle, with the inter-nibble carry held in a register.
import cla_multicycle_adder_pkg::*;

module cla_multicycle_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_op_q, a_op_d;
    logic [WIDTH-1:0] b_op_q, b_op_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic [WIDTH-1:0]    sum_merged;

    // Operand nibble selected by the running index.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_op_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_op_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    cla4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        sum_merged = sum_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sum_merged[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        a_op_d     = a_op_q;
        b_op_d     = b_op_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_op_d     = a;
                    b_op_d     = b;
                    carry_d    = cin;
                    idx_d      = '0;
                    sum_d      = '0;
                    cout_d     = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = sum_merged;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    // The last slice produces the result MSB, so overflow is known now.
                    cout_d     = slice_cout;
                    overflow_d = (a_op_q[WIDTH-1] == b_op_q[WIDTH-1])
                              && (slice_sum[NIBBLE_W-1] != a_op_q[WIDTH-1]);
                    idx_d      = '0;
                    state_d    = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_op_q      <= '0;
            b_op_q      <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_op_q      <= a_op_d;
            b_op_q      <= b_op_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;

endmodule
